// File: rtl/rst_seq_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : rst_seq_ctrl_pkg
// Brief   : Shared state encoding, default timing and counter sizing helper.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package rst_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_GATE_ON   = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_ACK_WAIT  = 3'd3,
    ST_NEXT      = 3'd4,
    ST_READY     = 3'd5
  } seq_state_t;

  localparam int C_HOLD_CYCLES = 16;
  localparam int C_STEP_CYCLES = 4;
  localparam int C_ACK_TIMEOUT = 64;

  // Smallest counter width w with 2**w strictly above every delay constant.
  function automatic int min_cnt_width(input int hold, input int step, input int ack_to);
    int m;
    int w;
    m = hold;
    if (step > m) m = step;
    if (ack_to > m) m = ack_to;
    w = 1;
    while ((1 << w) <= m) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_ctrl_delay_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : seq_delay_cnt
// Brief   : Clearable up-counter with terminal-count compare.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module seq_delay_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tc = (r_count == term);

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : rst_seq_ctrl
// Brief   : Sequenced per-domain reset release with clock-gate control.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_WIDTH   = 8,
  parameter int HOLD_CYCLES = C_HOLD_CYCLES,
  parameter int STEP_CYCLES = C_STEP_CYCLES,
  parameter int ACK_TIMEOUT = C_ACK_TIMEOUT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [NUM_DOMAINS-1:0] SW_RST_MASK,
  input  logic [NUM_DOMAINS-1:0] DOM_ACK,
  output logic [NUM_DOMAINS-1:0] DOM_RST_N,
  output logic [NUM_DOMAINS-1:0] CLK_GATE_EN,
  output logic                   SW_RST_ACK,
  output logic                   SEQ_BUSY,
  output logic                   SEQ_DONE,
  output logic [NUM_DOMAINS-1:0] SEQ_ERR
);

  localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

  seq_state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [NUM_DOMAINS-1:0] r_mask, w_mask_nxt;
  logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_n_nxt;
  logic [NUM_DOMAINS-1:0] r_gate, w_gate_nxt;
  logic [NUM_DOMAINS-1:0] r_err, w_err_nxt;
  logic [NUM_DOMAINS-1:0] w_sel;
  logic                   r_sw_ack, w_sw_ack_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   w_accept, w_acked, w_last, w_tc, w_cnt_clr;
  logic [CNT_WIDTH-1:0]   w_term;

  // One-hot select of the current domain; all zero once the index runs past the end.
  assign w_sel   = NUM_DOMAINS'(1) << r_idx;
  assign w_acked = |(DOM_ACK & w_sel);
  assign w_last  = (r_idx == IDX_W'(NUM_DOMAINS));

  always_comb begin
    w_term = '0;
    case (r_state)
      ST_HOLD:      w_term = CNT_WIDTH'(HOLD_CYCLES - 1);
      ST_STEP_WAIT: w_term = CNT_WIDTH'(STEP_CYCLES - 1);
      ST_ACK_WAIT:  w_term = CNT_WIDTH'(ACK_TIMEOUT - 1);
      default:      w_term = '0;
    endcase
  end

  // The counter restarts on every state change and idles at zero elsewhere.
  assign w_cnt_clr = (w_state_nxt != r_state) ||
                     !(r_state inside {ST_HOLD, ST_STEP_WAIT, ST_ACK_WAIT});

  seq_delay_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_delay_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (w_cnt_clr),
    .term (w_term),
    .tc   (w_tc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= ST_HOLD;
      r_idx    <= '0;
      r_mask   <= '1;
      r_rst_n  <= '0;
      r_gate   <= '0;
      r_err    <= '0;
      r_sw_ack <= 1'b0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_mask   <= w_mask_nxt;
      r_rst_n  <= w_rst_n_nxt;
      r_gate   <= w_gate_nxt;
      r_err    <= w_err_nxt;
      r_sw_ack <= w_sw_ack_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mask_nxt  = r_mask;
    w_accept    = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (w_tc) begin
          w_state_nxt = ST_NEXT;
          w_idx_nxt   = '0;
        end
      end
      ST_NEXT: begin
        if (w_last) begin
          w_state_nxt = ST_READY;
        end else if (!(|(r_mask & w_sel))) begin
          w_idx_nxt = r_idx + 1'b1;
        end else begin
          w_state_nxt = ST_GATE_ON;
        end
      end
      ST_GATE_ON: w_state_nxt = ST_STEP_WAIT;
      ST_STEP_WAIT: begin
        if (w_tc) w_state_nxt = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (w_acked || w_tc) begin
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = ST_NEXT;
        end
      end
      ST_READY: begin
        if (SW_RST_REQ && (|SW_RST_MASK)) begin
          w_accept    = 1'b1;
          w_mask_nxt  = SW_RST_MASK;
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_HOLD;
    endcase
  end

  always_comb begin
    w_rst_n_nxt  = r_rst_n;
    w_gate_nxt   = r_gate;
    w_err_nxt    = r_err;
    w_sw_ack_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = (w_state_nxt != ST_READY);
    case (r_state)
      ST_GATE_ON:   w_gate_nxt = r_gate | w_sel;
      ST_STEP_WAIT: if (w_tc) w_rst_n_nxt = r_rst_n | w_sel;
      // A timed-out domain stays released and clocked; only the flag records it.
      ST_ACK_WAIT:  if (!w_acked && w_tc) w_err_nxt = r_err | w_sel;
      ST_NEXT:      if (w_last) w_done_nxt = 1'b1;
      default: ;
    endcase
    if (w_accept) begin
      w_rst_n_nxt  = r_rst_n & ~SW_RST_MASK;
      w_gate_nxt   = r_gate & ~SW_RST_MASK;
      w_err_nxt    = r_err & ~SW_RST_MASK;
      w_sw_ack_nxt = 1'b1;
    end
  end

  assign DOM_RST_N   = r_rst_n;
  assign CLK_GATE_EN = r_gate;
  assign SEQ_ERR     = r_err;
  assign SW_RST_ACK  = r_sw_ack;
  assign SEQ_BUSY    = r_busy;
  assign SEQ_DONE    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_rst_seq_ctrl
// Brief   : Scoreboard bench for rst_seq_ctrl with directed reset scenarios.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_rst_seq_ctrl;
  import rst_seq_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SW_RST_REQ = 1'b0;
  logic [2:0] SW_RST_MASK = 3'b000;
  logic [2:0] DOM_ACK;
  logic [2:0] DOM_RST_N, CLK_GATE_EN, SEQ_ERR;
  logic       SW_RST_ACK, SEQ_BUSY, SEQ_DONE;

  // Acknowledge model: either straight through or two flops behind DOM_RST_N.
  logic       ack_imm = 1'b0;
  logic [2:0] ack_kill = 3'b000;
  logic [2:0] p1 = 3'b000, p2 = 3'b000;

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) begin
    p1 <= DOM_RST_N;
    p2 <= p1;
  end

  assign DOM_ACK = (ack_imm ? DOM_RST_N : p2) & ~ack_kill;

  rst_seq_ctrl #(
    .NUM_DOMAINS (3),
    .CNT_WIDTH   (min_cnt_width(16, 4, 64) + 1),
    .HOLD_CYCLES (16),
    .STEP_CYCLES (4),
    .ACK_TIMEOUT (64)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SW_RST_REQ  (SW_RST_REQ),
    .SW_RST_MASK (SW_RST_MASK),
    .DOM_ACK     (DOM_ACK),
    .DOM_RST_N   (DOM_RST_N),
    .CLK_GATE_EN (CLK_GATE_EN),
    .SW_RST_ACK  (SW_RST_ACK),
    .SEQ_BUSY    (SEQ_BUSY),
    .SEQ_DONE    (SEQ_DONE),
    .SEQ_ERR     (SEQ_ERR)
  );

  typedef struct {
    logic [2:0] rst_n;
    logic [2:0] gate;
    logic [2:0] err;
    logic       sw_ack;
    logic       done;
    logic       busy;
    int         dt;      // cycles since previous event; 0 = not checked
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_sw_ack = 0;
  int  n_ev     = 0;
  int  cyc      = 0;
  int  last_ev  = 0;
  int  base_cyc = 0;
  int  done_at  = 0;

  function automatic void expect_ev(input logic [2:0] r, input logic [2:0] g,
                                    input logic [2:0] e, input logic a,
                                    input logic d, input logic b, input int dt);
    ev_t x;
    x.rst_n = r; x.gate = g; x.err = e; x.sw_ack = a; x.done = d; x.busy = b; x.dt = dt;
    exp_q.push_back(x);
  endfunction

  // Monitor: an event is any change of the level outputs or a pulse output.
  initial begin
    logic [9:0] prev, cur;
    bit         have_prev;
    int         dt;
    ev_t        e;
    have_prev = 0;
    prev = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      cur = {DOM_RST_N, CLK_GATE_EN, SEQ_ERR, SEQ_BUSY};
      if (!have_prev) begin
        prev = cur;
        have_prev = 1;
      end else if (cur != prev || SW_RST_ACK || SEQ_DONE) begin
        dt = cyc - last_ev;
        last_ev = cyc;
        if (SW_RST_ACK) n_sw_ack++;
        if (SEQ_DONE) done_at = cyc - base_cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got rst_n=%b gate=%b err=%b ack=%b done=%b busy=%b dt=%0d, required no event",
                   DOM_RST_N, CLK_GATE_EN, SEQ_ERR, SW_RST_ACK, SEQ_DONE, SEQ_BUSY, dt);
        end else begin
          e = exp_q.pop_front();
          if (DOM_RST_N !== e.rst_n || CLK_GATE_EN !== e.gate || SEQ_ERR !== e.err ||
              SW_RST_ACK !== e.sw_ack || SEQ_DONE !== e.done || SEQ_BUSY !== e.busy ||
              (e.dt != 0 && dt != e.dt)) begin
            n_fail++;
            $display("FAIL event_%0d: got rst_n=%b gate=%b err=%b ack=%b done=%b busy=%b dt=%0d, required rst_n=%b gate=%b err=%b ack=%b done=%b busy=%b dt=%0d",
                     n_ev, DOM_RST_N, CLK_GATE_EN, SEQ_ERR, SW_RST_ACK, SEQ_DONE, SEQ_BUSY, dt,
                     e.rst_n, e.gate, e.err, e.sw_ack, e.done, e.busy, e.dt);
          end
        end
        n_ev++;
        prev = cur;
      end
      if (!RST) begin
        last_ev  = cyc;
        base_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge CLK);
      #1;
      i++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d events pending after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic sw_request(input logic [2:0] m);
    bit seen;
    seen = 0;
    @(negedge CLK);
    #1;
    SW_RST_MASK = m;
    SW_RST_REQ  = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (SW_RST_ACK) seen = 1;
    end
    #1;
    SW_RST_REQ  = 1'b0;
    SW_RST_MASK = 3'b000;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL sw_ack_wait: got no SW_RST_ACK in 10 cycles, required one");
    end
  endtask

  initial begin
    int acks_before;
    // Power-on sequence, acks returned two cycles after each release.
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    expect_ev(3'b000, 3'b001, 3'b000, 0, 0, 1, 18);
    expect_ev(3'b001, 3'b001, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b001, 3'b011, 3'b000, 0, 0, 1, 5);
    expect_ev(3'b011, 3'b011, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b011, 3'b111, 3'b000, 0, 0, 1, 5);
    expect_ev(3'b111, 3'b111, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b111, 3'b111, 3'b000, 0, 1, 0, 4);
    #1 RST = 1'b1;
    drain("power_on", 100);
    check_range("power_on_done_latency", done_at, 43, 45);

    // Software reset of domains 0 and 2; domain 1 must stay up.
    expect_ev(3'b010, 3'b010, 3'b000, 1, 0, 1, 0);
    expect_ev(3'b010, 3'b011, 3'b000, 0, 0, 1, 18);
    expect_ev(3'b011, 3'b011, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b011, 3'b111, 3'b000, 0, 0, 1, 6);
    expect_ev(3'b111, 3'b111, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b111, 3'b111, 3'b000, 0, 1, 0, 4);
    sw_request(3'b101);
    drain("sw_mask_101", 100);

    // Empty mask is not a request.
    acks_before = n_sw_ack;
    @(negedge CLK);
    #1;
    SW_RST_REQ = 1'b1;
    repeat (6) @(negedge CLK);
    check("mask_zero_busy", int'(SEQ_BUSY), 0);
    check("mask_zero_outputs", int'({DOM_RST_N, CLK_GATE_EN, SEQ_ERR}), int'(9'b111_111_000));
    check("mask_zero_acks", n_sw_ack - acks_before, 0);
    #1 SW_RST_REQ = 1'b0;

    // Domain 1 never acknowledges: timeout flag after 64 cycles, domain 2 still runs.
    ack_kill = 3'b010;
    expect_ev(3'b000, 3'b000, 3'b000, 1, 0, 1, 0);
    expect_ev(3'b000, 3'b001, 3'b000, 0, 0, 1, 18);
    expect_ev(3'b001, 3'b001, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b001, 3'b011, 3'b000, 0, 0, 1, 5);
    expect_ev(3'b011, 3'b011, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b011, 3'b011, 3'b010, 0, 0, 1, 64);
    expect_ev(3'b011, 3'b111, 3'b010, 0, 0, 1, 2);
    expect_ev(3'b111, 3'b111, 3'b010, 0, 0, 1, 4);
    expect_ev(3'b111, 3'b111, 3'b010, 0, 1, 0, 4);
    sw_request(3'b111);
    drain("ack_timeout", 200);

    // Resetting domain 1 clears its flag; a request pulsed during HOLD is dropped.
    ack_kill = 3'b000;
    acks_before = n_sw_ack;
    expect_ev(3'b101, 3'b101, 3'b000, 1, 0, 1, 0);
    expect_ev(3'b101, 3'b111, 3'b000, 0, 0, 1, 19);
    expect_ev(3'b111, 3'b111, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b111, 3'b111, 3'b000, 0, 1, 0, 5);
    sw_request(3'b010);
    repeat (4) @(negedge CLK);
    #1;
    SW_RST_MASK = 3'b111;
    SW_RST_REQ  = 1'b1;
    @(negedge CLK);
    #1;
    SW_RST_REQ  = 1'b0;
    SW_RST_MASK = 3'b000;
    drain("busy_request", 100);
    check("busy_request_acks", n_sw_ack - acks_before, 1);

    // Async reset in the middle of domain 1's step wait, then full restart.
    ack_imm = 1'b1;
    expect_ev(3'b000, 3'b000, 3'b000, 1, 0, 1, 0);
    expect_ev(3'b000, 3'b001, 3'b000, 0, 0, 1, 18);
    expect_ev(3'b001, 3'b001, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b001, 3'b011, 3'b000, 0, 0, 1, 3);
    expect_ev(3'b000, 3'b000, 3'b000, 0, 0, 1, 0);
    sw_request(3'b111);
    repeat (26) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({DOM_RST_N, CLK_GATE_EN, SEQ_ERR, SW_RST_ACK, SEQ_DONE, SEQ_BUSY}),
          int'(12'b000_000_000_0_0_1));
    drain("async_reset", 10);
    expect_ev(3'b000, 3'b001, 3'b000, 0, 0, 1, 18);
    expect_ev(3'b001, 3'b001, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b001, 3'b011, 3'b000, 0, 0, 1, 3);
    expect_ev(3'b011, 3'b011, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b011, 3'b111, 3'b000, 0, 0, 1, 3);
    expect_ev(3'b111, 3'b111, 3'b000, 0, 0, 1, 4);
    expect_ev(3'b111, 3'b111, 3'b000, 0, 1, 0, 2);
    repeat (2) @(negedge CLK);
    #1 RST = 1'b1;
    drain("restart", 100);
    check_range("restart_done_latency", done_at, 37, 39);

    repeat (10) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
